// File: rtl/alu_seq_pkg.sv
// Shared constants for the nibble-serial ALU sequencer: opcodes, FSM states, slice width.
package alu_seq_pkg;

    localparam int unsigned NIB_W = 4;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    function automatic logic is_arith(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/alu_nibble_sequencer_if.sv
// Request / ALU-slice / response bundle for alu_nibble_sequencer.
// rsp_ovf exists only when ALU_SEQ_OVF_EN is defined.
interface alu_nibble_sequencer_if #(
    parameter int unsigned NIBBLES = 4
);
    import alu_seq_pkg::*;

    localparam int unsigned W = NIB_W * NIBBLES;

    logic             req_valid;
    logic             req_ready;
    logic [W-1:0]     req_a;
    logic [W-1:0]     req_b;
    logic             req_cin;
    logic [2:0]       req_op;

    logic [NIB_W-1:0] alu_a;
    logic [NIB_W-1:0] alu_b;
    logic             alu_cin;
    logic [2:0]       alu_opcode;
    logic [NIB_W-1:0] alu_result;
    logic             alu_carry;

    logic             rsp_valid;
    logic             rsp_ready;
    logic [W-1:0]     rsp_result;
    logic             rsp_carry;
    logic             rsp_zero;
    logic             rsp_err;
`ifdef ALU_SEQ_OVF_EN
    logic             rsp_ovf;
`endif

    modport slave (
`ifdef ALU_SEQ_OVF_EN
        output rsp_ovf,
`endif
        input  req_valid, req_a, req_b, req_cin, req_op,
        output req_ready,
        output alu_a, alu_b, alu_cin, alu_opcode,
        input  alu_result, alu_carry,
        output rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
        input  rsp_ready
    );

    modport master (
`ifdef ALU_SEQ_OVF_EN
        input  rsp_ovf,
`endif
        output req_valid, req_a, req_b, req_cin, req_op,
        input  req_ready,
        input  alu_a, alu_b, alu_cin, alu_opcode,
        output alu_result, alu_carry,
        input  rsp_valid, rsp_result, rsp_carry, rsp_zero, rsp_err,
        output rsp_ready
    );

endinterface

// File: rtl/alu_nibble_sequencer.sv
// Steps a wide add/sub/AND/OR through an external 4-bit ALU, LSB slice first.
// Define ALU_SEQ_OVF_EN to add the signed-overflow response flag rsp_ovf.
module alu_nibble_sequencer
    import alu_seq_pkg::*;
#(
    parameter int unsigned NIBBLES = 4
) (
    input  logic clk,
    input  logic rst,
    alu_nibble_sequencer_if.slave bus
);

    localparam int unsigned W     = NIB_W * NIBBLES;
    localparam int unsigned IDX_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    state_t           state, state_next;
    logic [IDX_W-1:0] idx;
    logic [W-1:0]     a_r, b_r, result_r;
    logic             cin_r, carry_r, err_r;
    logic [2:0]       op_r;
    logic             last;

    assign last = (idx == LAST_IDX);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next     = state;
        bus.req_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_cin    = 1'b0;
        case (state)
            S_IDLE: begin
                bus.req_ready = 1'b1;
                if (bus.req_valid) state_next = bus.req_op[2] ? S_DONE : S_RUN;
            end
            S_RUN: begin
                bus.alu_a = a_r[idx*NIB_W +: NIB_W];
                bus.alu_b = b_r[idx*NIB_W +: NIB_W];
                // Logic ops must not see a carry; slice 0 takes the request's cin.
                if (is_arith(op_r)) bus.alu_cin = (idx == '0) ? cin_r : carry_r;
                if (last) state_next = S_DONE;
            end
            S_DONE: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx      <= '0;
            a_r      <= '0;
            b_r      <= '0;
            result_r <= '0;
            cin_r    <= 1'b0;
            carry_r  <= 1'b0;
            err_r    <= 1'b0;
            op_r     <= OP_ADD;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.req_valid) begin
                        a_r      <= bus.req_a;
                        b_r      <= bus.req_b;
                        cin_r    <= bus.req_cin;
                        idx      <= '0;
                        result_r <= '0;
                        carry_r  <= 1'b0;
                        err_r    <= bus.req_op[2];
                        // Illegal ops never reach the ALU, so its opcode keeps the last legal one.
                        if (!bus.req_op[2]) op_r <= bus.req_op;
                    end
                end
                S_RUN: begin
                    result_r[idx*NIB_W +: NIB_W] <= bus.alu_result;
                    carry_r <= is_arith(op_r) ? bus.alu_carry : 1'b0;
                    idx     <= idx + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.alu_opcode = op_r;
    assign bus.rsp_result = result_r;
    assign bus.rsp_carry  = carry_r;
    assign bus.rsp_err    = err_r;
    assign bus.rsp_zero   = (state == S_DONE) && (result_r == '0);

`ifdef ALU_SEQ_OVF_EN
    logic ovf_add, ovf_sub;
    assign ovf_add = (a_r[W-1] == b_r[W-1]) && (result_r[W-1] != a_r[W-1]);
    assign ovf_sub = (a_r[W-1] != b_r[W-1]) && (result_r[W-1] != a_r[W-1]);
    assign bus.rsp_ovf = !err_r && (((op_r == OP_ADD) && ovf_add) || ((op_r == OP_SUB) && ovf_sub));
`endif

endmodule

// File: tb/tb_alu_nibble_sequencer.sv
// Self-checking bench for alu_nibble_sequencer with an ideal 4-bit ALU model attached.
module tb_alu_nibble_sequencer;
    import alu_seq_pkg::*;

    localparam int unsigned NIB = 4;
    localparam int unsigned W   = 4 * NIB;

    typedef struct packed {
        logic [W-1:0] res;
        logic         c;
        logic         z;
        logic         err;
        logic         ovf;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_nibble_sequencer_if #(.NIBBLES(NIB)) bus ();

    alu_nibble_sequencer #(.NIBBLES(NIB)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int   n_assert = 0;
    int   n_fail   = 0;
    logic logic_carry;

    // Ideal 4-bit ALU; for logic ops the carry output is a stale/forced value the DUT must ignore.
    always_comb begin
        logic [4:0] s;
        s = '0;
        case (bus.alu_opcode)
            3'b000:  s = {1'b0, bus.alu_a} + {1'b0, bus.alu_b} + {4'b0, bus.alu_cin};
            3'b001:  s = {1'b0, bus.alu_a} + {1'b0, ~bus.alu_b} + {4'b0, bus.alu_cin};
            3'b010:  s = {logic_carry, bus.alu_a & bus.alu_b};
            3'b011:  s = {logic_carry, bus.alu_a | bus.alu_b};
            default: s = {logic_carry, 4'h0};
        endcase
        bus.alu_result = s[3:0];
        bus.alu_carry  = s[4];
    end

    int   run_cycles;
    logic run_cin_seen, ab_seen;
    always @(negedge clk) begin
        if (!rst && !bus.req_ready && !bus.rsp_valid) begin
            run_cycles++;
            if (bus.alu_cin) run_cin_seen = 1'b1;
        end
        if (bus.alu_a != 4'h0 || bus.alu_b != 4'h0) ab_seen = 1'b1;
    end

    // Wide reference: sub is A + ~B + cin, matching the nibble ALU's carry convention.
    function automatic exp_t model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic cin);
        exp_t e;
        logic [W:0] s;
        e = '0;
        s = '0;
        case (op)
            3'b000: begin
                s = {1'b0, a} + {1'b0, b} + (W+1)'(cin);
                e.ovf = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'b001: begin
                s = {1'b0, a} + {1'b0, ~b} + (W+1)'(cin);
                e.ovf = (a[W-1] != b[W-1]) && (s[W-1] != a[W-1]);
            end
            3'b010:  s = {1'b0, a & b};
            3'b011:  s = {1'b0, a | b};
            default: e.err = 1'b1;
        endcase
        e.res = s[W-1:0];
        e.c   = s[W];
        e.z   = (s[W-1:0] == '0);
        return e;
    endfunction

    // Present one request, wait for it to be accepted, then count edges until rsp_valid (-1 on timeout).
    task automatic issue(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cin, output int edges);
        int guard;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = op;
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_cin   = cin;
        guard = 0;
        while (!bus.req_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        @(posedge clk);
        @(negedge clk);
        bus.req_valid = 1'b0;
        edges = 0;
        while (!bus.rsp_valid && edges < 100) begin
            @(negedge clk);
            edges++;
        end
        if (!bus.rsp_valid) edges = -1;
    endtask

    task automatic release_rsp();
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        logic [16:0] obs;
        rst = 1'b1;
        @(negedge clk);
        obs = {bus.req_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_err,
               bus.alu_cin, bus.alu_opcode, bus.alu_a, bus.alu_b};
        n_assert++;
        if (obs !== 17'h10000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %h expected %h", obs, 17'h10000);
        end
        n_assert++;
        if (bus.rsp_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL reset_result: got %h expected 0000", bus.rsp_result);
        end
`ifdef ALU_SEQ_OVF_EN
        n_assert++;
        if (bus.rsp_ovf !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ovf: got %b expected 0", bus.rsp_ovf);
        end
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_assert++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset: got ready=%b valid=%b expected ready=1 valid=0",
                     bus.req_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_add_directed();
        int edges;
        issue(OP_ADD, 16'h0FFF, 16'h0001, 1'b0, edges);
        n_assert++;
        if (edges !== NIB) begin
            n_fail++;
            $display("FAIL add1_latency: got %0d expected %0d", edges, NIB);
        end
        n_assert++;
        if ({bus.rsp_result, bus.rsp_carry, bus.rsp_zero} !== {16'h1000, 1'b0, 1'b0}) begin
            n_fail++;
            $display("FAIL add1_rsp: got res=%h c=%b z=%b expected res=1000 c=0 z=0",
                     bus.rsp_result, bus.rsp_carry, bus.rsp_zero);
        end
        release_rsp();
        issue(OP_ADD, 16'hFFFF, 16'h0001, 1'b0, edges);
        n_assert++;
        if ({bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err} !== {16'h0000, 1'b1, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL add2_rsp: got res=%h c=%b z=%b e=%b expected res=0000 c=1 z=1 e=0",
                     bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err);
        end
        release_rsp();
`ifdef ALU_SEQ_OVF_EN
        issue(OP_ADD, 16'h7FFF, 16'h0001, 1'b0, edges);
        n_assert++;
        if (bus.rsp_ovf !== 1'b1 || bus.rsp_result !== 16'h8000) begin
            n_fail++;
            $display("FAIL add_ovf: got ovf=%b res=%h expected ovf=1 res=8000", bus.rsp_ovf, bus.rsp_result);
        end
        release_rsp();
`endif
    endtask

    task automatic test_and_forced_carry();
        int edges;
        logic_carry  = 1'b1;
        run_cycles   = 0;
        run_cin_seen = 1'b0;
        issue(OP_AND, 16'hF0F0, 16'h3C3C, 1'b1, edges);
        n_assert++;
        if (bus.rsp_result !== 16'h3030 || bus.rsp_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL and_rsp: got res=%h c=%b expected res=3030 c=0", bus.rsp_result, bus.rsp_carry);
        end
        n_assert++;
        if (run_cin_seen !== 1'b0 || run_cycles !== NIB) begin
            n_fail++;
            $display("FAIL and_cin: got cin_seen=%b run_cycles=%0d expected cin_seen=0 run_cycles=%0d",
                     run_cin_seen, run_cycles, NIB);
        end
        release_rsp();
        logic_carry = 1'b0;
    endtask

    task automatic test_illegal();
        int edges;
        ab_seen = 1'b0;
        issue(3'b101, 16'hA5A5, 16'h5A5A, 1'b1, edges);
        n_assert++;
        if (edges !== 0) begin
            n_fail++;
            $display("FAIL illegal_latency: got %0d expected 0 (valid in the cycle after accept)", edges);
        end
        n_assert++;
        if ({bus.rsp_err, bus.rsp_result, bus.rsp_carry} !== {1'b1, 16'h0000, 1'b0}) begin
            n_fail++;
            $display("FAIL illegal_rsp: got e=%b res=%h c=%b expected e=1 res=0000 c=0",
                     bus.rsp_err, bus.rsp_result, bus.rsp_carry);
        end
        n_assert++;
        if (ab_seen !== 1'b0 || bus.alu_opcode !== OP_AND) begin
            n_fail++;
            $display("FAIL illegal_alu: got ab_seen=%b opcode=%b expected ab_seen=0 opcode=010",
                     ab_seen, bus.alu_opcode);
        end
        release_rsp();
    endtask

    task automatic test_backpressure();
        int    edges, guard;
        exp_t  e1, e2;
        logic [W+3:0] snap;
        e1 = model(OP_ADD, 16'h1234, 16'h4321, 1'b1);
        e2 = model(OP_OR, 16'h0F00, 16'h00F0, 1'b0);
        issue(OP_ADD, 16'h1234, 16'h4321, 1'b1, edges);
        snap = {bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err};
        n_assert++;
        if (snap !== {1'b1, e1.res, e1.c, e1.z, e1.err}) begin
            n_fail++;
            $display("FAIL bp_first: got %h expected %h", snap, {1'b1, e1.res, e1.c, e1.z, e1.err});
        end
        bus.req_valid = 1'b1;
        bus.req_op    = OP_OR;
        bus.req_a     = 16'h0F00;
        bus.req_b     = 16'h00F0;
        bus.req_cin   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_assert++;
            if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err} !== snap
                || bus.req_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL bp_hold[%0d]: got rsp=%h ready=%b expected rsp=%h ready=0", i,
                         {bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err},
                         bus.req_ready, snap);
            end
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        @(negedge clk);
        n_assert++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_return_idle: got ready=%b valid=%b expected ready=1 valid=0",
                     bus.req_ready, bus.rsp_valid);
        end
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        n_assert++;
        if (bus.req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_second_accept: got ready=%b expected 0", bus.req_ready);
        end
        guard = 0;
        while (!bus.rsp_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        n_assert++;
        if ({bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_err} !== {1'b1, e2.res, e2.c, e2.err}) begin
            n_fail++;
            $display("FAIL bp_second_rsp: got v=%b res=%h c=%b e=%b expected v=1 res=%h c=%b e=%b",
                     bus.rsp_valid, bus.rsp_result, bus.rsp_carry, bus.rsp_err, e2.res, e2.c, e2.err);
        end
        release_rsp();
    endtask

    task automatic test_reset_in_run();
        logic [16:0]  obs;
        logic [W-1:0] a, b;
        int           edges, seen;
        exp_t         e;
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.req_op    = OP_SUB;
        bus.req_a     = 16'h9876;
        bus.req_b     = 16'h1234;
        bus.req_cin   = 1'b1;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        obs = {bus.req_ready, bus.rsp_valid, bus.rsp_carry, bus.rsp_zero, bus.rsp_err,
               bus.alu_cin, bus.alu_opcode, bus.alu_a, bus.alu_b};
        n_assert++;
        if (obs !== 17'h10000 || bus.rsp_result !== 16'h0000) begin
            n_fail++;
            $display("FAIL rst_in_run: got ctrl=%h res=%h expected ctrl=10000 res=0000", obs, bus.rsp_result);
        end
        @(negedge clk);
        rst  = 1'b0;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) seen++;
        end
        n_assert++;
        if (seen !== 0) begin
            n_fail++;
            $display("FAIL rst_no_rsp: got %0d valid cycles expected 0", seen);
        end
        a = W'($urandom);
        b = W'($urandom);
        e = model(OP_ADD, a, b, 1'b1);
        issue(OP_ADD, a, b, 1'b1, edges);
        n_assert++;
        if ({bus.rsp_result, bus.rsp_carry} !== {e.res, e.c} || edges !== NIB) begin
            n_fail++;
            $display("FAIL rst_next_op: got res=%h c=%b lat=%0d expected res=%h c=%b lat=%0d",
                     bus.rsp_result, bus.rsp_carry, edges, e.res, e.c, NIB);
        end
        release_rsp();
    endtask

    task automatic test_random();
        logic [2:0]   op;
        logic [W-1:0] a, b;
        logic         cin;
        int           edges;
        exp_t         e;
        for (int n = 0; n < 24; n++) begin
            op  = ($urandom_range(0, 4) == 4) ? {1'b1, 2'($urandom)} : 3'($urandom_range(0, 3));
            a   = W'($urandom);
            b   = W'($urandom);
            cin = 1'($urandom);
            if (n % 6 == 0) b = ~a;
            logic_carry = 1'($urandom);
            e = model(op, a, b, cin);
            issue(op, a, b, cin, edges);
            n_assert++;
            if ({bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err} !== {e.res, e.c, e.z, e.err}
                || edges !== (e.err ? 0 : NIB)) begin
                n_fail++;
                $display("FAIL rand[%0d] op=%b a=%h b=%h cin=%b: got res=%h c=%b z=%b e=%b lat=%0d expected res=%h c=%b z=%b e=%b lat=%0d",
                         n, op, a, b, cin, bus.rsp_result, bus.rsp_carry, bus.rsp_zero, bus.rsp_err, edges,
                         e.res, e.c, e.z, e.err, e.err ? 0 : NIB);
            end
`ifdef ALU_SEQ_OVF_EN
            n_assert++;
            if (bus.rsp_ovf !== e.ovf) begin
                n_fail++;
                $display("FAIL rand_ovf[%0d]: got %b expected %b", n, bus.rsp_ovf, e.ovf);
            end
`endif
            repeat ($urandom_range(0, 3)) @(negedge clk);
            release_rsp();
        end
        logic_carry = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [2:0]   ops [5];
        logic [W-1:0] as  [5];
        logic [W-1:0] bs  [5];
        logic         cs  [5];
        exp_t         q[$];
        exp_t         e;
        int           acc_cyc[$];
        int           next, got;
        bit           acc_prev;
        for (int i = 0; i < 5; i++) begin
            ops[i] = 3'($urandom_range(0, 3));
            as[i]  = W'($urandom);
            bs[i]  = W'($urandom);
            cs[i]  = 1'($urandom);
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        bus.req_valid = 1'b1;
        {bus.req_op, bus.req_a, bus.req_b, bus.req_cin} = {ops[0], as[0], bs[0], cs[0]};
        next     = 1;
        got      = 0;
        acc_prev = 1'b0;
        for (int cyc = 0; cyc < 100 && got < 5; cyc++) begin
            if (acc_prev) begin
                if (next < 5) begin
                    {bus.req_op, bus.req_a, bus.req_b, bus.req_cin} = {ops[next], as[next], bs[next], cs[next]};
                    next++;
                end else begin
                    bus.req_valid = 1'b0;
                end
            end
            acc_prev = bus.req_valid && bus.req_ready;
            if (acc_prev) begin
                q.push_back(model(bus.req_op, bus.req_a, bus.req_b, bus.req_cin));
                acc_cyc.push_back(cyc);
            end
            if (bus.rsp_valid) begin
                e = (q.size() > 0) ? q.pop_front() : '0;
                n_assert++;
                if ({bus.rsp_result, bus.rsp_carry, bus.rsp_err} !== {e.res, e.c, e.err}) begin
                    n_fail++;
                    $display("FAIL b2b_rsp[%0d]: got res=%h c=%b e=%b expected res=%h c=%b e=%b",
                             got, bus.rsp_result, bus.rsp_carry, bus.rsp_err, e.res, e.c, e.err);
                end
                got++;
            end
            @(negedge clk);
        end
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b0;
        n_assert++;
        if (got !== 5) begin
            n_fail++;
            $display("FAIL b2b_count: got %0d responses expected 5", got);
        end
        for (int i = 1; i < acc_cyc.size(); i++) begin
            n_assert++;
            if (acc_cyc[i] - acc_cyc[i-1] !== NIB + 2) begin
                n_fail++;
                $display("FAIL b2b_interval[%0d]: got %0d cycles expected %0d", i,
                         acc_cyc[i] - acc_cyc[i-1], NIB + 2);
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req_valid = 1'b0;
        bus.req_op    = 3'b000;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_cin   = 1'b0;
        bus.rsp_ready = 1'b0;
        logic_carry   = 1'b0;
        run_cycles    = 0;
        run_cin_seen  = 1'b0;
        ab_seen       = 1'b0;
        test_reset();
        test_add_directed();
        test_and_forced_carry();
        test_illegal();
        test_backpressure();
        test_reset_in_run();
        test_random();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
